bp_me_lce_req_arb: RTL and testbench
====================================

Name: bp_me_lce_req_arb

Overview:
- Shares one CCE LCE-request input port among num_lce_p LCE request sources (icache and dcache of every core).
- Arbitrates round-robin among the requesters that are both valid and eligible. A requester is eligible only while it holds a per-LCE credit, which caps its outstanding requests.
- Registers the winning request into a one-entry output buffer that feeds the CCE.
- Sits between the per-core FE/BE LCE request outputs and bp_me_top lce_req_i, on the multi-core top.

Parameters:
- num_lce_p, 4, number of requesting LCEs (2 per core).
- req_width_p, 64, width of the packed bp_lce_cce_req_s.
- credits_p, 2, maximum outstanding requests per LCE; must be at least 1.
- lce_id_width_lp, clog2(num_lce_p), derived local; width of the grant ID.
- credit_width_lp, clog2(credits_p+1), derived local; width of each credit counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  num_lce_p x req_width_p  per-LCE request payload.
- req_v_i  in  num_lce_p  per-LCE request valid.
- req_yumi_o  out  num_lce_p  one-hot dequeue/grant back to the LCE (valid-then-yumi).
- req_o  out  req_width_p  buffered request to the CCE.
- req_lce_id_o  out  lce_id_width_lp  index of the LCE that owns req_o.
- req_v_o  out  1  output buffer valid.
- req_yumi_i  in  1  CCE consumes req_o this cycle; legal only when req_v_o=1.
- credit_return_i  in  num_lce_p  one credit returned per set bit (pulsed by the CCE when the request completes).
- credits_o  out  num_lce_p x credit_width_lp  current credit counts, for debug/trace.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous and active-high.
- Reset values: req_v_o=0, req_yumi_o=0, req_o and req_lce_id_o=0, every credit counter=credits_p, RR pointer=0. Reset asserted mid-operation discards the buffered request and all in-flight credit state.
- Eligibility: elig[i] = req_v_i[i] & (credit[i]!=0).
- Buffer acceptance: can_accept = ~req_v_o | req_yumi_i (bypass-on-dequeue gives full throughput).
- Grant search: search elig starting at index ptr, wrapping from num_lce_p-1 to 0. The first hit g is the winner.
- Grant: when can_accept and any elig, req_yumi_o[g]=1 for that cycle only. req_yumi_o is combinational from req_v_i and state, never from req_yumi_i's future; at most one bit is set.
- Grant effects on the next clock edge:
  - req_o<=req_i[g], req_lce_id_o<=g, req_v_o<=1.
  - ptr<=(g+1) mod num_lce_p.
  - credit[g] decrements.
- Dequeue without new grant: req_v_o<=0. ptr holds when no grant occurs.
- Latency: 1 cycle from req_yumi_o to req_v_o. Sustained 1 request/cycle while the CCE yumis every cycle.
- Credit update: each counter's next value is credit + return - grant.
  - Simultaneous grant and return on the same LCE leave the counter unchanged.
  - A return while the counter equals credits_p is a protocol error: the counter saturates and a simulation-only assertion fires.
  - A grant is never issued with credit 0, so the counter cannot underflow.
- Stability: req_o and req_lce_id_o hold while req_v_o=1 and req_yumi_i=0.
- Fairness: any continuously eligible requester is granted within num_lce_p grants.
- Error: req_yumi_i with req_v_o=0 fires a simulation assertion; the RTL ignores it.

Decomposition:
- bp_common_pkg / bp_me macros: req_width_p is derived from the existing `bp_lce_cce_req_width macro at the instantiating top. No new typedefs are needed beyond a localparam for the credit width.
- Round-robin selection: use bsg_arb_round_robin if its interface allows the ptr-after-grant update. Otherwise write a local rotate-and-priority-encode function.
- Sub-module bp_me_lce_credit_ctr:
  - One saturating up/down counter per LCE with reset value credits_p.
  - Inputs: grant, return. Outputs: count, nonzero.
  - Instantiated num_lce_p times in a generate loop.

Test Plan:
- Reset, then all four LCEs valid continuously, CCE yumis every cycle, no credit returns -> grants in order 0,1,2,3,0,1,2,3. Eight grants, then every credit is 0 and req_yumi_o stays 0.
- Credits_p=2, only LCE2 valid, credit_return_i[2] pulsed 3 cycles after each grant -> two back-to-back grants, a stall, then one grant per return. credits_o[2] never exceeds 2.
- LCE1 granted and credit_return_i[1] pulsed in the same cycle with credit[1]=1 -> credit[1] stays 1 and LCE1 remains eligible.
- CCE holds req_yumi_i=0 for 5 cycles with req_v_o=1 and all requesters valid -> req_yumi_o=0 throughout; req_o and req_lce_id_o stable. On yumi, the next grant goes to the (ptr) winner in the same cycle.
- reset_i asserted for 1 cycle while req_v_o=1 and credits partly consumed -> next cycle req_v_o=0, all credits=2, first grant goes to LCE0.
- Credit return to an LCE already at credits_p -> counter stays at credits_p and the assertion fires (negative test, expected failure flagged).

Source files
------------

// File: rtl/bp_me_lce_req_arb_pkg.sv
// Shared helpers for the LCE request arbiter.
// No ports. It provides the width helpers that size the grant ID and the
// credit counters, and it holds the default parameter values.
package bp_me_lce_req_arb_pkg;

   localparam int unsigned default_num_lce_lp   = 4;
   localparam int unsigned default_req_width_lp = 64;
   localparam int unsigned default_credits_lp   = 2;

   // Width of an index into n items. It is never smaller than 1, so a
   // single-LCE build still has a legal ID port.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width that can hold every value from 0 to max_count inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count > 0) ? $clog2(max_count + 1) : 1;
   endfunction

endpackage

// File: rtl/bp_me_lce_credit_ctr.sv
// Per-LCE credit counter. It resets to credits_p, counts down on each grant
// and counts up on each return.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   grant      : a request from this LCE was accepted this cycle
//   ret        : the CCE returned one credit this cycle
//   count      : current credit count
//   nonzero    : the LCE may be granted
module bp_me_lce_credit_ctr
   import bp_me_lce_req_arb_pkg::*;
#(
   parameter  int unsigned credits_p       = default_credits_lp,
   localparam int unsigned credit_width_lp = cnt_width(credits_p)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       grant,
   input  logic                       ret,
   output logic [credit_width_lp-1:0] count,
   output logic                       nonzero
);

   localparam logic [credit_width_lp-1:0] max_lp = credit_width_lp'(credits_p);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= max_lp;
      end else begin
         unique case ({ret, grant})
            2'b10:   if (count != max_lp) count <= count + credit_width_lp'(1);
            2'b01:   count <= count - credit_width_lp'(1);
            default: count <= count;
         endcase
      end
   end

   assign nonzero = (count != '0);

   // A return while the counter is already full is a CCE protocol error.
   // The counter saturates in that case.
   assert property (@(posedge clk) disable iff (reset)
      !(ret && !grant && count == max_lp));

   // The arbiter gates on nonzero, so this can only trip on a design bug.
   assert property (@(posedge clk) disable iff (reset)
      !(grant && count == '0));

endmodule

// File: rtl/bp_me_lce_req_arb.sv
// Round-robin, credit-limited arbiter that shares one CCE LCE-request port
// among num_lce_p LCE request sources. The winning request is registered
// into a one-entry output buffer.
// Ports:
//   clk_i, reset_i  : clock and synchronous active-high reset
//   req_i, req_v_i  : per-LCE request payload and valid
//   req_yumi_o      : one-hot dequeue back to the winning LCE
//   req_o, req_lce_id_o, req_v_o : buffered request to the CCE and its owner
//   req_yumi_i      : the CCE consumes req_o
//   credit_return_i : per-LCE credit return pulses
//   credits_o       : current credit counts, for debug and trace
module bp_me_lce_req_arb
   import bp_me_lce_req_arb_pkg::*;
#(
   parameter  int unsigned num_lce_p       = default_num_lce_lp,
   parameter  int unsigned req_width_p     = default_req_width_lp,
   parameter  int unsigned credits_p       = default_credits_lp,
   localparam int unsigned lce_id_width_lp = id_width(num_lce_p),
   localparam int unsigned credit_width_lp = cnt_width(credits_p)
) (
   input  logic                                       clk_i,
   input  logic                                       reset_i,
   input  logic [num_lce_p-1:0][req_width_p-1:0]      req_i,
   input  logic [num_lce_p-1:0]                       req_v_i,
   output logic [num_lce_p-1:0]                       req_yumi_o,
   output logic [req_width_p-1:0]                     req_o,
   output logic [lce_id_width_lp-1:0]                 req_lce_id_o,
   output logic                                       req_v_o,
   input  logic                                       req_yumi_i,
   input  logic [num_lce_p-1:0]                       credit_return_i,
   output logic [num_lce_p-1:0][credit_width_lp-1:0]  credits_o
);

   logic [num_lce_p-1:0]       has_credit;
   logic [num_lce_p-1:0]       elig;
   logic [lce_id_width_lp-1:0] ptr;
   logic [lce_id_width_lp-1:0] grant_id;
   logic                       grant_found;
   logic                       can_accept;
   logic                       grant_v;

   // Rotate-and-priority-encode. The result is {found, index}; the search
   // starts at ptr and wraps.
   function automatic logic [lce_id_width_lp:0] rr_pick(
      input logic [num_lce_p-1:0]       e,
      input logic [lce_id_width_lp-1:0] p
   );
      logic [lce_id_width_lp:0] res;
      int                       idx;
      res = '0;
      for (int k = 0; k < int'(num_lce_p); k++) begin
         idx = (int'(p) + k) % int'(num_lce_p);
         if (!res[lce_id_width_lp] && e[idx]) begin
            res = {1'b1, lce_id_width_lp'(idx)};
         end
      end
      return res;
   endfunction

   assign elig                      = req_v_i & has_credit;
   assign can_accept                = ~req_v_o | req_yumi_i;
   assign {grant_found, grant_id}   = rr_pick(elig, ptr);
   assign grant_v                   = ~reset_i & can_accept & grant_found;

   always_comb begin
      req_yumi_o = '0;
      if (grant_v) req_yumi_o[grant_id] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         req_v_o      <= 1'b0;
         req_o        <= '0;
         req_lce_id_o <= '0;
         ptr          <= '0;
      end else if (grant_v) begin
         req_v_o      <= 1'b1;
         req_o        <= req_i[grant_id];
         req_lce_id_o <= grant_id;
         ptr          <= (int'(grant_id) == int'(num_lce_p) - 1)
                         ? '0 : grant_id + lce_id_width_lp'(1);
      end else if (req_yumi_i) begin
         req_v_o      <= 1'b0;
      end
   end

   for (genvar i = 0; i < int'(num_lce_p); i++) begin : g_credit
      bp_me_lce_credit_ctr #(.credits_p(credits_p)) u_ctr (
         .clk     (clk_i),
         .reset   (reset_i),
         .grant   (req_yumi_o[i]),
         .ret     (credit_return_i[i]),
         .count   (credits_o[i]),
         .nonzero (has_credit[i])
      );
   end

   assert property (@(posedge clk_i) disable iff (reset_i)
      !(req_yumi_i && !req_v_o));

   assert property (@(posedge clk_i) disable iff (reset_i)
      $onehot0(req_yumi_o));

endmodule

// File: tb/tb_bp_me_lce_req_arb.sv
module tb_bp_me_lce_req_arb;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int CR = 2;
   localparam int IW = 2;
   localparam int CW = 2;

   logic                    clk_i = 1'b0;
   logic                    reset_i;
   logic [N-1:0][W-1:0]     req_i;
   logic [N-1:0]            req_v_i;
   logic [N-1:0]            req_yumi_o;
   logic [W-1:0]            req_o;
   logic [IW-1:0]           req_lce_id_o;
   logic                    req_v_o;
   logic                    req_yumi_i;
   logic [N-1:0]            credit_return_i;
   logic [N-1:0][CW-1:0]    credits_o;

   bp_me_lce_req_arb #(.num_lce_p(N), .req_width_p(W), .credits_p(CR)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .req_i           (req_i),
      .req_v_i         (req_v_i),
      .req_yumi_o      (req_yumi_o),
      .req_o           (req_o),
      .req_lce_id_o    (req_lce_id_o),
      .req_v_o         (req_v_o),
      .req_yumi_i      (req_yumi_i),
      .credit_return_i (credit_return_i),
      .credits_o       (credits_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model: credits per LCE, next search start, buffered request.
   int          m_cred [N];
   int          m_ptr;
   bit          m_v;
   logic [W-1:0] m_data;
   int          m_id;

   // Observations from the most recent cycle.
   logic [N-1:0]        obs_yumi;
   logic                obs_v;
   logic [IW-1:0]       obs_id;
   logic [N-1:0][CW-1:0] obs_cred;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cred[i] = CR;
      m_ptr  = 0;
      m_v    = 0;
      m_data = '0;
      m_id   = 0;
   endtask

   // One clock cycle: apply inputs, compare the DUT with the model, advance
   // the model, then move to just after the next rising edge.
   task automatic cycle(input logic [N-1:0] v, input logic yumi,
                        input logic [N-1:0] ret, input logic rst);
      int g;
      logic [N-1:0] exp_yumi;
      logic [N-1:0][CW-1:0] exp_cred;
      reset_i         = rst;
      req_v_i         = v;
      req_yumi_i      = yumi;
      credit_return_i = ret;
      for (int i = 0; i < N; i++) req_i[i] = {$urandom, $urandom};
      #3;
      g = -1;
      if (!rst && (!m_v || yumi)) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx] && m_cred[idx] > 0) g = idx;
         end
      end
      exp_yumi = '0;
      if (g >= 0) exp_yumi[g] = 1'b1;
      for (int i = 0; i < N; i++) exp_cred[i] = CW'(m_cred[i]);
      obs_yumi = req_yumi_o;
      obs_v    = req_v_o;
      obs_id   = req_lce_id_o;
      obs_cred = credits_o;
      if (!rst) begin
         chk("yumi_o", W'(req_yumi_o), W'(exp_yumi));
         chk("v_o", W'(req_v_o), W'(m_v));
         chk("lce_id_o", W'(req_lce_id_o), W'(m_id));
         chk("req_o", req_o, m_data);
         chk("credits_o", W'(credits_o), W'(exp_cred));
      end
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < N; i++) begin
            m_cred[i] = m_cred[i] + int'(ret[i]) - ((g == i) ? 1 : 0);
            if (m_cred[i] > CR) m_cred[i] = CR;
         end
         if (g >= 0) begin
            m_v    = 1;
            m_data = req_i[g];
            m_id   = g;
            m_ptr  = (g + 1) % N;
         end else if (yumi) begin
            m_v = 0;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   typedef struct {
      logic [N-1:0] v;
      logic         yumi;
      logic [N-1:0] exp_yumi;
      logic         exp_v;
      logic [IW-1:0] exp_id;
   } vec_t;

   vec_t tbl [10];
   bit   ret_sched [64];

   initial begin
      reset_i = 1'b1; req_v_i = '0; req_yumi_i = 1'b0; credit_return_i = '0;
      for (int i = 0; i < N; i++) req_i[i] = '0;
      model_reset();
      @(posedge clk_i); #1;

      // Full load without credit returns: strict 0,1,2,3 rotation until the
      // credits run out.
      tbl[0] = '{4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
      tbl[1] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0};
      tbl[2] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1};
      tbl[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2};
      tbl[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3};
      tbl[5] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0};
      tbl[6] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1};
      tbl[7] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2};
      tbl[8] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd3};
      tbl[9] = '{4'hF, 1'b0, 4'b0000, 1'b0, 2'd3};
      cycle('0, 1'b0, '0, 1'b1);
      for (int r = 0; r < 10; r++) begin
         cycle(tbl[r].v, tbl[r].yumi, '0, 1'b0);
         chk($sformatf("tbl%0d_yumi", r), W'(obs_yumi), W'(tbl[r].exp_yumi));
         chk($sformatf("tbl%0d_v", r), W'(obs_v), W'(tbl[r].exp_v));
         if (tbl[r].exp_v) chk($sformatf("tbl%0d_id", r), W'(obs_id), W'(tbl[r].exp_id));
      end
      chk("tbl_credits_empty", W'(obs_cred), W'(0));

      // Single requester with delayed credit returns.
      cycle('0, 1'b0, '0, 1'b1);
      for (int t = 0; t < 64; t++) ret_sched[t] = 0;
      for (int t = 0; t < 24; t++) begin
         cycle(4'b0100, m_v, ret_sched[t] ? 4'b0100 : 4'b0000, 1'b0);
         if (obs_yumi[2] && t + 3 < 64) ret_sched[t+3] = 1;
         if (t == 0) chk("lce2_first", W'(obs_yumi), W'(4'b0100));
         if (t == 1) chk("lce2_second", W'(obs_yumi), W'(4'b0100));
         if (t == 2) chk("lce2_stall", W'(obs_yumi), W'(4'b0000));
         chk("lce2_cred_max", W'(obs_cred[2] <= CW'(CR)), W'(1));
      end

      // Grant and return on the same LCE in the same cycle.
      cycle('0, 1'b0, '0, 1'b1);
      cycle(4'b0010, 1'b0, 4'b0000, 1'b0);
      cycle(4'b0010, 1'b1, 4'b0010, 1'b0);
      chk("same_cycle_grant", W'(obs_yumi), W'(4'b0010));
      cycle(4'b0010, 1'b1, 4'b0000, 1'b0);
      chk("same_cycle_cred", W'(obs_cred[1]), W'(1));
      chk("same_cycle_elig", W'(obs_yumi), W'(4'b0010));

      // CCE back-pressure for 5 cycles, then release.
      cycle('0, 1'b0, '0, 1'b1);
      cycle(4'hF, 1'b0, '0, 1'b0);
      for (int t = 0; t < 5; t++) begin
         cycle(4'hF, 1'b0, '0, 1'b0);
         chk("hold_no_grant", W'(obs_yumi), W'(0));
         chk("hold_id", W'(obs_id), W'(0));
      end
      cycle(4'hF, 1'b1, '0, 1'b0);
      chk("release_grant", W'(obs_yumi), W'(4'b0010));

      // Reset in the middle of operation.
      cycle('0, 1'b0, '0, 1'b1);
      cycle(4'hF, 1'b0, '0, 1'b0);
      cycle(4'hF, 1'b1, '0, 1'b0);
      cycle(4'hF, 1'b1, '0, 1'b0);
      cycle(4'hF, 1'b0, '0, 1'b1);
      cycle(4'hF, 1'b0, '0, 1'b0);
      chk("rst_v", W'(obs_v), W'(0));
      chk("rst_credits", W'(obs_cred), W'(8'hAA));
      chk("rst_first_grant", W'(obs_yumi), W'(4'b0001));

      // Randomized traffic against the model.
      for (int t = 0; t < 3000; t++) begin
         logic [N-1:0] v, ret;
         logic y, r;
         v = N'($urandom);
         y = m_v && ($urandom_range(0, 3) != 0);
         ret = '0;
         for (int i = 0; i < N; i++)
            if (m_cred[i] < CR && $urandom_range(0, 2) == 0) ret[i] = 1'b1;
         r = ($urandom_range(0, 199) == 0);
         cycle(v, y, ret, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
